// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder with a one-entry valid/ready output stage and optional shift splitting.
// Define ALU_CTRL_MULTICYCLE_SHIFT_EN to split shifts into micro-ops of at most STEP positions.
`timescale 1ns/1ps
module alu_ctrl_pipe #(
    parameter int SHAMT_W = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         ALU_op,
    input  logic [1:0]         ALU_funct,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               invA,
    output logic               invB,
    output logic               sign,
    output logic               cin,
    output logic               passA,
    output logic               passB,
    output logic [2:0]         op_to_alu,
    output logic [SHAMT_W-1:0] amt,
    output logic               last
);

    typedef enum logic [1:0] {EMPTY, HOLD, MULTI} state_t;

    typedef struct packed {
        logic       inv_a;
        logic       inv_b;
        logic       sign;
        logic       cin;
        logic       pass_a;
        logic       pass_b;
        logic [2:0] op;
    } ctrl_t;

`ifdef ALU_CTRL_MULTICYCLE_SHIFT_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_t               state;
    ctrl_t                ctrl_q;
    ctrl_t                dec;
    logic                 dec_shift;
    logic [SHAMT_W-1:0]   rem;
    logic [SHAMT_W-1:0]   load_amt, load_rem;
    logic [SHAMT_W-1:0]   step_amt, step_rem;
    logic                 accept;

    function automatic logic [SHAMT_W-1:0] chunk(input logic [SHAMT_W-1:0] r);
        return (r > STEP_AMT) ? STEP_AMT : r;
    endfunction

    assign out_valid = (state != EMPTY);
    assign in_ready  = !out_valid || (out_ready && last);
    assign accept    = in_valid && in_ready;

    assign invA      = ctrl_q.inv_a;
    assign invB      = ctrl_q.inv_b;
    assign sign      = ctrl_q.sign;
    assign cin       = ctrl_q.cin;
    assign passA     = ctrl_q.pass_a;
    assign passB     = ctrl_q.pass_b;
    assign op_to_alu = ctrl_q.op;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec       = '0;
        dec_shift = 1'b0;
        unique case (ALU_op)
            5'b11011: begin
                unique case (ALU_funct)
                    2'b00:   dec.op = 3'b100;
                    2'b01:   begin dec.op = 3'b100; dec.inv_a = 1'b1; dec.cin = 1'b1; end
                    2'b10:   dec.op = 3'b110;
                    default: begin dec.op = 3'b111; dec.inv_b = 1'b1; end
                endcase
            end
            5'b11111, 5'b10000, 5'b10001, 5'b10011, 5'b11001: dec.op = 3'b100;
            5'b01000: begin dec.op = 3'b100; dec.sign = 1'b1; end
            5'b11100, 5'b01001: begin dec.op = 3'b100; dec.inv_a = 1'b1; dec.cin = 1'b1; end
            5'b11101, 5'b11110: begin dec.op = 3'b100; dec.inv_b = 1'b1; dec.cin = 1'b1; end
            5'b01010: dec.op = 3'b110;
            5'b01011: begin dec.op = 3'b111; dec.inv_b = 1'b1; end
            5'b10010: dec.op = 3'b101;
            5'b11000: dec.pass_b = 1'b1;
            5'b11010: begin dec.op = {1'b0, ALU_funct}; dec_shift = 1'b1; end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                dec.op    = {1'b0, ALU_op[1:0]};
                dec_shift = 1'b1;
            end
            default: ;
        endcase
    end

    // Chunks never exceed what remains, so the subtractions cannot wrap.
    always_comb begin
        load_amt = '0;
        load_rem = '0;
        if (dec_shift) begin
            if (MULTI_EN) begin
                load_amt = chunk(shamt);
                load_rem = shamt - load_amt;
            end else begin
                load_amt = shamt;
            end
        end
        step_amt = chunk(rem);
        step_rem = rem - step_amt;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            ctrl_q <= '0;
            amt    <= '0;
            last   <= 1'b0;
            rem    <= '0;
        end else if (accept) begin
            ctrl_q <= dec;
            amt    <= load_amt;
            rem    <= load_rem;
            last   <= (load_rem == '0);
            state  <= (load_rem == '0) ? HOLD : MULTI;
        end else if (out_valid && out_ready) begin
            if (state == MULTI) begin
                amt   <= step_amt;
                rem   <= step_rem;
                last  <= (step_rem == '0);
                state <= (step_rem == '0) ? HOLD : MULTI;
            end else begin
                state  <= EMPTY;
                ctrl_q <= '0;
                amt    <= '0;
                last   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 Parameter SHAMT_W, default 4: width of shift-amount field.
REQ-002 Parameter STEP, default 1: maximum shift distance per micro-op when multi-cycle shift is enabled; range 1..2^SHAMT_W-1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  upstream instruction present.
REQ-006 in_ready  out  1  block accepts instruction this cycle.
REQ-007 ALU_op  in  5  opcode field; ALU_funct  in  2  function field; shamt  in  SHAMT_W  requested shift amount.
REQ-008 out_valid  out  1  micro-op present; out_ready  in  1  downstream consumes micro-op.
REQ-009 invA, invB, sign, cin, passA, passB  out  1 each; op_to_alu  out  3  decoded ALU controls.
REQ-010 amt  out  SHAMT_W  shift distance for this micro-op; last  out  1  final micro-op of instruction.

Function
REQ-011 Accept on in_valid && in_ready; in_ready = !out_valid || (out_ready && last).
REQ-012 Latency 1: accepted instruction appears on outputs with out_valid=1 the next cycle; back-to-back acceptance sustains 1 instruction/cycle for single-micro-op instructions.
REQ-013 Outputs held stable while out_valid && !out_ready.
REQ-014 Decode {ALU_op,ALU_funct}, unlisted controls 0: ADD 11011_00, SCO 11111, ST 10000, LD 10001, STU 10011, BTR 11001 -> op 100; ADDI 01000 -> op 100, sign=1.
REQ-015 SUB 11011_01, SEQ 11100, SUBI 01001 -> op 100, invA=1, cin=1; SLT 11101, SLE 11110 -> op 100, invB=1, cin=1.
REQ-016 XOR 11011_10, XORI 01010 -> op 110; ANDN 11011_11, ANDNI 01011 -> op 111, invB=1; SLBI 10010 -> op 101; LBI 11000 -> op 000, passB=1.
REQ-017 Shifts: ROL 11010_00/ROLI 10100 -> 000; SLL 11010_01/SLLI 10101 -> 001; ROR 11010_10/RORI 10110 -> 010; SRL 11010_11/SRLI 10111 -> 011.
REQ-018 All other codes, including HALT 00000, emit one micro-op with all controls 0, amt=0, last=1.
REQ-019 Non-shift instructions: one micro-op, amt=0, last=1.
REQ-020 States: EMPTY (out_valid=0), HOLD (single/final micro-op pending), MULTI (non-final shift micro-op pending, remaining count registered).
REQ-021 Transitions: EMPTY->HOLD/MULTI on accept; HOLD->EMPTY on out_ready without accept; HOLD->HOLD/MULTI on out_ready with accept; MULTI->MULTI/HOLD on out_ready; no state change while out_ready=0.
REQ-022 Remaining-count arithmetic is unsigned SHAMT_W bits, never wraps below 0.

Reset
REQ-023 rst forces EMPTY; out_valid=0, last=0, amt=0, all control outputs 0; in_ready=1 the cycle after reset.
REQ-024 rst during MULTI discards remaining micro-ops; no partial output follows reset.
REQ-025 rst dominates a simultaneous accept; the instruction is dropped.

Configuration
REQ-026 Macro ALU_CTRL_MULTICYCLE_SHIFT_EN.
REQ-027 Defined: shift of shamt=k issues ceil(k/STEP) micro-ops, each amt=min(STEP, remaining), last only on final; k=0 issues one micro-op amt=0, last=1; in_ready=0 until final micro-op consumed.
REQ-028 Undefined: every shift issues one micro-op with amt=shamt, last=1; MULTI state unreachable; STEP ignored.

Verification
REQ-029 Reset then ADD (11011,00) valid, out_ready=1 -> next cycle out_valid=1, op=100, all flags 0, last=1.
REQ-030 SUBI (01001) with out_ready=0 for 3 cycles -> outputs invA=1, cin=1, op=100 held constant; in_ready=0 during stall; released on out_ready=1.
REQ-031 Macro defined, STEP=1, SLLI shamt=3, out_ready=1 -> 3 micro-ops op=001, amt=1, last=0,0,1; in_ready low for first two.
REQ-032 Macro defined, STEP=2, RORI shamt=5 -> amt=2,2,1, last on third; macro undefined same stimulus -> single micro-op amt=5, last=1.
REQ-033 Macro defined, SRLI shamt=4, assert rst after 2nd micro-op -> next cycle out_valid=0, in_ready=1, no further micro-ops.
REQ-034 Opcode 00110 (unlisted), then XOR back-to-back -> micro-op all zeros last=1, then op=110, one per cycle with out_ready=1.
